// File: rtl/ttl_magnitude_comparator_serial.sv
// Serial multi-word magnitude comparator, the clocked successor to the
// cascadable 4-bit comparator. A and B arrive one chunk per clock, most
// significant chunk first, between First and Last. The first unequal
// chunk latches the decision. When every chunk is equal, the result comes
// from the cascade inputs, using the classic expansion semantics.
//
// Build option: define TTL_SERIAL_CMP_SIGNED_EN to treat the operands as
// two's complement. The sign is taken from the MSB of the First chunk.
module ttl_magnitude_comparator_serial #(
    parameter int WIDTH_IN   = 4,
    parameter int MAX_CHUNKS = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                Clk,
    input  logic                Clear_bar,
    input  logic                Valid,
    input  logic                First,
    input  logic                Last,
    input  logic [WIDTH_IN-1:0] A,
    input  logic [WIDTH_IN-1:0] B,
    input  logic                ALess_in,
    input  logic                Equal_in,
    input  logic                AGreater_in,
    output logic                ALess_out,
    output logic                Equal_out,
    output logic                AGreater_out,
    output logic                Busy,
    output logic                Done,
    output logic                Overflow
);

    localparam int             CW      = $clog2(MAX_CHUNKS + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_CHUNKS);

    // Rise/fall delays are not modelled in the synthesizable netlist.
    // Output timing is left to implementation. Negative values are rejected.
    if ((DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_bad_delay
        $error("DELAY_RISE/DELAY_FALL must be non-negative");
    end

    typedef enum logic [1:0] {IDLE, COMPARE, DONE, ERROR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          decided_q, decided_d;
    logic          less_q, less_d;
    logic          alt_q, aeq_q, agt_q;
    logic          busy_q, done_q, ovf_q;
    logic          chunk_lt, chunk_gt;
    logic          accept;

    // Order of the current chunk pair (sign-aware on the First chunk when enabled)
    always_comb begin
        chunk_lt = (A < B);
        chunk_gt = (A > B);
`ifdef TTL_SERIAL_CMP_SIGNED_EN
        if (First && (A[WIDTH_IN-1] != B[WIDTH_IN-1])) begin
            chunk_lt = A[WIDTH_IN-1];
            chunk_gt = B[WIDTH_IN-1];
        end
`endif
    end

    // Chunk acceptance, counter advance and sticky decision update
    always_comb begin
        accept    = Valid && (First || (state_q == COMPARE));
        cnt_d     = cnt_q;
        decided_d = decided_q;
        less_d    = less_q;
        if (First) begin
            cnt_d     = CW'(1);
            decided_d = chunk_lt | chunk_gt;
            less_d    = chunk_lt;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (!decided_q) begin
                decided_d = chunk_lt | chunk_gt;
                less_d    = chunk_lt;
            end
        end
    end

    // FSM with registered outputs. Results change only on entry to DONE/ERROR or on reset.
    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            less_q    <= 1'b0;
            alt_q     <= 1'b0;
            aeq_q     <= 1'b0;
            agt_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            less_q    <= less_d;
            if (Last) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                ovf_q   <= 1'b0;
                if (decided_d) begin
                    alt_q <= less_d;
                    aeq_q <= 1'b0;
                    agt_q <= ~less_d;
                end else begin
                    alt_q <= ~Equal_in & ~AGreater_in;
                    aeq_q <= Equal_in;
                    agt_q <= ~Equal_in & ~ALess_in;
                end
            end else if (cnt_d == MAX_CNT) begin
                state_q <= ERROR;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                ovf_q   <= 1'b1;
                alt_q   <= 1'b0;
                aeq_q   <= 1'b0;
                agt_q   <= 1'b0;
            end else begin
                state_q <= COMPARE;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end
        end
    end

    assign ALess_out    = alt_q;
    assign Equal_out    = aeq_q;
    assign AGreater_out = agt_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Overflow     = ovf_q;

endmodule

// File: tb/tb_ttl_magnitude_comparator_serial.sv
// Self-checking bench for ttl_magnitude_comparator_serial.
// The reference model assembles each operand as a whole integer. It then
// compares the full values, which gives the ordering the chunked
// decision must reproduce.
module tb_ttl_magnitude_comparator_serial;

    localparam int W = 4;
    localparam int M = 4;

    logic         Clk = 1'b0;
    logic         Clear_bar, Valid, First, Last;
    logic [W-1:0] A, B;
    logic         ALess_in, Equal_in, AGreater_in;
    logic         ALess_out, Equal_out, AGreater_out, Busy, Done, Overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_active = 1'b0;
    int          m_n      = 0;
    longint      m_a      = 0;
    longint      m_b      = 0;
    logic [5:0]  m_exp    = '0;   // {lt, eq, gt, busy, done, ovf}

    ttl_magnitude_comparator_serial #(
        .WIDTH_IN  (W),
        .MAX_CHUNKS(M),
        .DELAY_RISE(0),
        .DELAY_FALL(0)
    ) dut (
        .Clk         (Clk),
        .Clear_bar   (Clear_bar),
        .Valid       (Valid),
        .First       (First),
        .Last        (Last),
        .A           (A),
        .B           (B),
        .ALess_in    (ALess_in),
        .Equal_in    (Equal_in),
        .AGreater_in (AGreater_in),
        .ALess_out   (ALess_out),
        .Equal_out   (Equal_out),
        .AGreater_out(AGreater_out),
        .Busy        (Busy),
        .Done        (Done),
        .Overflow    (Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic model_update(input logic rn, v, f, l,
                                input logic [W-1:0] a, b,
                                input logic [2:0] cas);
        longint sa, sb;
        int     bits;
        if (!rn) begin
            m_active = 1'b0;
            m_n      = 0;
            m_exp    = '0;
        end else if (v && (f || m_active)) begin
            if (f) begin
                m_n = 0;
                m_a = 0;
                m_b = 0;
            end
            m_n++;
            m_a = (m_a << W) | longint'(a);
            m_b = (m_b << W) | longint'(b);
            if (l) begin
                m_active = 1'b0;
                sa   = m_a;
                sb   = m_b;
                bits = m_n * W;
`ifdef TTL_SERIAL_CMP_SIGNED_EN
                if (sa[bits-1]) sa = sa - (longint'(1) << bits);
                if (sb[bits-1]) sb = sb - (longint'(1) << bits);
`endif
                if (sa < sb)      m_exp[5:3] = 3'b100;
                else if (sa > sb) m_exp[5:3] = 3'b001;
                else begin
                    // cas = {ALess_in, Equal_in, AGreater_in}
                    m_exp[4] = cas[1];
                    m_exp[5] = !cas[1] && !cas[0];
                    m_exp[3] = !cas[1] && !cas[2];
                end
                m_exp[2:0] = 3'b010;
            end else if (m_n == M) begin
                m_active = 1'b0;
                m_exp    = 6'b000_011;
            end else begin
                m_active   = 1'b1;
                m_exp[2:0] = 3'b100;
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after it
    task automatic cyc(input logic rn, v, f, l,
                       input logic [W-1:0] a, b,
                       input logic [2:0] cas,
                       input string tag);
        logic [5:0] obs;
        Clear_bar = rn;
        Valid     = v;
        First     = f;
        Last      = l;
        A         = a;
        B         = b;
        {ALess_in, Equal_in, AGreater_in} = cas;
        @(posedge Clk);
        model_update(rn, v, f, l, a, b, cas);
        #1;
        obs = {ALess_out, Equal_out, AGreater_out, Busy, Done, Overflow};
        checks++;
        assert (obs === m_exp) else begin
            errors++;
            $error("FAIL %s: {lt,eq,gt,busy,done,ovf} observed=%b expected=%b",
                   tag, obs, m_exp);
        end
    endtask

    task automatic idle(input string tag);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000, tag);
    endtask

    // Send n chunks MSB-first. Optional stall cycles go between chunks.
    // do_last=0 omits Last.
    task automatic cmp(input int n, input logic [15:0] a, b,
                       input logic [2:0] cas, input int stall,
                       input bit do_last, input string tag);
        logic [15:0] av, bv;
        av = a;
        bv = b;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, i == 0, do_last && (i == n - 1),
                av[(n-1-i)*W +: W], bv[(n-1-i)*W +: W], cas, tag);
            if (i != n - 1)
                for (int s = 0; s < stall; s++) idle({tag, "_stall"});
        end
    endtask

    logic [2:0] sweep [5] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b101};

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000, "reset0");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000, "reset1");

        // Reset mid-comparison, then Valid without First must be ignored
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h7, 3'b010, "mid_chunk1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 4'h2, 3'b010, "mid_chunk2");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'h3, 3'b010, "mid_reset");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'h3, 3'b010, "idle_ignore");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 4'h3, 3'b010, "idle_ignore_last");

        // All chunks equal: the result comes from the cascade inputs
        foreach (sweep[k]) begin
            cmp(4, 16'hA50F, 16'hA50F, sweep[k], 0, 1'b1, "eq_cascade");
            idle("eq_cascade_hold");
        end

        // Early decision with stalls; cascade inputs ignored
        cmp(3, 16'h03FF, 16'h0400, 3'b010, 3, 1'b1, "early_less");
        idle("early_less_hold");
        cmp(3, 16'h0400, 16'h03FF, 3'b010, 3, 1'b1, "early_greater");
        idle("early_greater_hold");

        // Single chunk (signed build expects less)
        cmp(1, 16'h0009, 16'h0002, 3'b000, 0, 1'b1, "single");

        // Overflow, ignored chunk in ERROR, then restart
        cmp(4, 16'h1234, 16'h1234, 3'b010, 0, 1'b0, "overflow");
        idle("overflow_hold");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 4'h0, 3'b010, "error_ignore");
        cmp(1, 16'h0000, 16'h0000, 3'b010, 0, 1'b1, "restart");

        // Abort: First on chunk 2 discards the earlier decision
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h8, 3'b000, "abort_c1");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 3'b000, "abort_new");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 3'b000, "abort_last");

        // First&Last while in COMPARE
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 4'h9, 3'b000, "fl_c1");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'h6, 4'h6, 3'b001, "fl_single");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic         rn, v, f, l;
            logic [W-1:0] a, b;
            logic [2:0]   cas;
            rn  = ($urandom_range(0, 59) != 0);
            v   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 5) == 0);
            l   = ($urandom_range(0, 3) == 0);
            a   = W'($urandom);
            b   = ($urandom_range(0, 1) != 0) ? a : W'($urandom);
            cas = 3'($urandom);
            cyc(rn, v, f, l, a, b, cas, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
